// File: rtl/machine_timer_if.sv
// Peripheral data-bus bundle for the machine timer: select, register strobes, write data and read data.
interface machine_timer_if;
    logic        sel;
    logic [4:0]  addr;
    logic [31:0] data_in;
    logic        write_en;
    logic        read_en;
    logic [31:0] data_out;

    modport master (output sel, addr, data_in, write_en, read_en, input data_out);
    modport slave  (input sel, addr, data_in, write_en, read_en, output data_out);
endinterface

// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp with prescaler, periodic auto-reload,
// sticky match flag and an atomic lo/hi read latch; drives the core's intr_timer level.
module machine_timer #(
    parameter int unsigned DIV_WIDTH = 8,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic            clk,
    input  logic            reset,
    machine_timer_if.slave  bus,
    output logic            intr_timer
);

    typedef enum logic [4:0] {
        REG_MTIME_LO = 5'h00,
        REG_MTIME_HI = 5'h04,
        REG_CMP_LO   = 5'h08,
        REG_CMP_HI   = 5'h0C,
        REG_CTRL     = 5'h10,
        REG_STATUS   = 5'h14,
        REG_PERIOD   = 5'h18
    } reg_addr_e;

    logic [63:0]          mtime_q, mtime_d;
    logic [63:0]          mtimecmp_q, mtimecmp_d;
    logic [31:0]          period_q, period_d;
    logic                 en_q, en_d;
    logic                 ie_q, ie_d;
    logic                 auto_q, auto_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] pcnt_q, pcnt_d;
    logic                 match_q, match_d;
    logic [31:0]          hi_shadow_q, hi_shadow_d;
    logic                 intr_q, intr_d;

    logic        wr, rd;
    logic        tick, hit;
    logic [63:0] reload_sum;
    logic [31:0] ctrl_rd;

    assign wr = bus.sel & bus.write_en;
    assign rd = bus.sel & bus.read_en;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        tick       = en_q && (pcnt_q == div_q);
        hit        = (mtime_q >= mtimecmp_q);
        reload_sum = mtimecmp_q + {32'd0, period_q};

        pcnt_d      = pcnt_q;
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        period_d    = period_q;
        en_d        = en_q;
        ie_d        = ie_q;
        auto_d      = auto_q;
        div_d       = div_q;
        hi_shadow_d = hi_shadow_q;

        if (wr && bus.addr == REG_CTRL) begin
            pcnt_d = '0;
            en_d   = bus.data_in[0];
            ie_d   = bus.data_in[1];
            auto_d = bus.data_in[2];
            div_d  = bus.data_in[8 +: DIV_WIDTH];
        end else if (en_q) begin
            pcnt_d = tick ? '0 : pcnt_q + DIV_WIDTH'(1);
        end

        // A software write to either half replaces the tick increment outright, carry included.
        if (wr && bus.addr == REG_MTIME_LO)      mtime_d[31:0]  = bus.data_in;
        else if (wr && bus.addr == REG_MTIME_HI) mtime_d[63:32] = bus.data_in;
        else if (tick)                           mtime_d        = mtime_q + 64'd1;

        // A write beats the reload; the unwritten half keeps its pre-reload value.
        if (wr && bus.addr == REG_CMP_LO)        mtimecmp_d[31:0]  = bus.data_in;
        else if (wr && bus.addr == REG_CMP_HI)   mtimecmp_d[63:32] = bus.data_in;
        else if (auto_q && tick && hit)          mtimecmp_d        = reload_sum;

        if (wr && bus.addr == REG_PERIOD) period_d = bus.data_in;

        if (rd && bus.addr == REG_MTIME_LO) hi_shadow_d = mtime_q[63:32];

        match_d = hit | (match_q & ~(wr && bus.addr == REG_STATUS && bus.data_in[0]));
        intr_d  = hit & ie_q;
    end

    always_comb begin
        ctrl_rd                  = '0;
        ctrl_rd[2:0]             = {auto_q, ie_q, en_q};
        ctrl_rd[8 +: DIV_WIDTH]  = div_q;

        bus.data_out = '0;
        case (bus.addr)
            REG_MTIME_LO: bus.data_out = mtime_q[31:0];
            REG_MTIME_HI: bus.data_out = hi_shadow_q;
            REG_CMP_LO:   bus.data_out = mtimecmp_q[31:0];
            REG_CMP_HI:   bus.data_out = mtimecmp_q[63:32];
            REG_CTRL:     bus.data_out = ctrl_rd;
            REG_STATUS:   bus.data_out = {31'd0, match_q};
            REG_PERIOD:   bus.data_out = period_q;
            default:      bus.data_out = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mtime_q     <= '0;
            mtimecmp_q  <= CMP_RESET;
            period_q    <= '0;
            en_q        <= 1'b0;
            ie_q        <= 1'b0;
            auto_q      <= 1'b0;
            div_q       <= '0;
            pcnt_q      <= '0;
            match_q     <= 1'b0;
            hi_shadow_q <= '0;
            intr_q      <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            period_q    <= period_d;
            en_q        <= en_d;
            ie_q        <= ie_d;
            auto_q      <= auto_d;
            div_q       <= div_d;
            pcnt_q      <= pcnt_d;
            match_q     <= match_d;
            hi_shadow_q <= hi_shadow_d;
            intr_q      <= intr_d;
        end
    end

    assign intr_timer = intr_q;

endmodule

// File: doc/machine_timer.md
Name: machine_timer

Overview:
- Memory-mapped RISC-V machine timer with a 64-bit mtime counter and 64-bit mtimecmp compare register.
- Drives the level-sensitive intr_timer input of the core's CSR/interrupt unit, i.e. it is the source end of that interrupt line.
- Sits on the core's peripheral data bus next to the UART.
- Provides a prescaler, a periodic auto-reload mode and a sticky match flag.

Parameters:
- DIV_WIDTH, 8, width of the prescaler divide field and counter.
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp. The default guarantees no interrupt out of reset.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- sel  input  1  block selected by bus decoder
- addr  input  5  word-aligned register offset
- data_in  input  32  write data
- write_en  input  1  write strobe; acts only when sel=1
- read_en  input  1  read strobe; acts only when sel=1 (used for the hi-latch side effect only)
- data_out  output  32  combinational read data
- intr_timer  output  1  registered timer interrupt level to the CSR unit

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset=0 resets on the clk edge).
- Reset values:
  - mtime=0; mtimecmp=CMP_RESET; period=0; ctrl=0; prescale count=0
  - match flag=0; hi shadow=0; intr_timer=0
  - data_out follows the reset register values.
- Register map (offset: register):
  - 0x00 mtime[31:0]
  - 0x04 mtime[63:32]
  - 0x08 mtimecmp[31:0]
  - 0x0C mtimecmp[63:32]
  - 0x10 ctrl: [0] EN, [1] IE, [2] AUTO, [8+:DIV_WIDTH] DIV
  - 0x14 status: [0] MATCH, W1C
  - 0x18 period, 32-bit
  - Unmapped offsets read 0; writes to them are ignored.
- Tick:
  - When EN=1, the prescale counter counts 0..DIV. On reaching DIV it returns to 0 and asserts tick for 1 cycle.
  - DIV=0 gives a tick every cycle.
  - EN=0 freezes the counter and mtime.
  - Writing ctrl clears the prescale counter.
- mtime increments by 1 per tick, full 64-bit with carry, wrapping from all-ones to 0.
- Compare: hit = (mtime >= mtimecmp), unsigned 64-bit, evaluated on current register values every cycle.
- intr_timer <= hit && IE. Latency is 1 cycle from hit becoming true. Level output: it stays high until mtimecmp is raised, mtime is written lower, or IE is cleared.
- MATCH is set on any cycle with hit=1 and stays set until software writes 1 to status[0]. If set and clear coincide, set wins.
- AUTO mode: on a tick cycle with hit=1, mtimecmp <= mtimecmp + zero-extended period (64-bit, wrapping). period=0 leaves mtimecmp unchanged.
- Writes to mtime/mtimecmp halves replace only that half, in the cycle of write_en.
  - A software write to mtime in a tick cycle suppresses that increment; the write wins, and the other half also keeps its value with no carry propagation.
  - A software write to mtimecmp in the same cycle as an AUTO reload: the write wins for the written half; the other half keeps its pre-reload value.
- Hi-latch:
  - A read (sel && read_en) of 0x00 captures mtime[63:32] into the hi shadow.
  - A read of 0x04 returns the shadow, not live mtime[63:32].
  - A lo-then-hi read pair is therefore atomic.
  - Reads have no other side effects.
- Reset mid-count overrides all pending writes and ticks that cycle.

Test Plan:
- Reset with EN=0 → intr_timer=0, MATCH=0. Read 0x08/0x0C → 0xFFFFFFFF/0xFFFFFFFF. mtime stays 0 for 100 cycles.
- ctrl=EN, DIV=3 → mtime increments once every 4 cycles; after 40 cycles mtime=10.
- DIV=0, EN=1, IE=1, mtimecmp=20 → intr_timer rises exactly 1 cycle after mtime reaches 20 and stays high. Write mtimecmp lo=100 → intr_timer low next cycle. MATCH remains 1 until W1C.
- Wrap: write mtime hi=0xFFFFFFFF, lo=0xFFFFFFFE; DIV=0, EN=1 → mtime goes ...FFFE, ...FFFF, 0x0. Read lo=0x00000001 then hi → 0x00000000.
- AUTO=1, period=50, mtimecmp=50, IE=1, DIV=0 → MATCH set at mtime=50, 100, 150; mtimecmp reads 200 after mtime=150. Software write of mtimecmp lo=500 in a reload cycle → mtimecmp lo=500.
- Assert reset=0 for 1 cycle mid-count with intr_timer=1 → next cycle intr_timer=0, mtime=0, ctrl=0, mtimecmp=CMP_RESET.
